// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit and its memory.
// HALT_OPCODE is only meaningful when the block is built with HALT_OPCODE_EN.
package fetch_pkg;

  localparam int IMEM_DEPTH  = 64;
  localparam int INSTR_WIDTH = 8;
  localparam int PC_WIDTH    = $clog2(IMEM_DEPTH);

  localparam logic [INSTR_WIDTH-1:0] HALT_OPCODE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  // Decode splits each opcode into register-file and ALU control fields.
  localparam int RF_CTRL_MSB  = 7;
  localparam int RF_CTRL_LSB  = 2;
  localparam int ALU_CTRL_MSB = 1;
  localparam int ALU_CTRL_LSB = 0;

  typedef struct packed {
    logic [RF_CTRL_MSB-RF_CTRL_LSB:0]   rf_ctrl;
    logic [ALU_CTRL_MSB-ALU_CTRL_LSB:0] alu_ctrl;
  } opcode_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Load and instruction-stream channels of the fetch unit.
// master: the fetch unit itself; slave: the program loader plus decode.
interface fetch_if;
  import fetch_pkg::*;

  logic                   load_valid;
  logic                   load_ready;
  logic [INSTR_WIDTH-1:0] load_data;
  logic                   load_last;

  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instr;
  logic [PC_WIDTH-1:0]    instr_pc;

  modport master (
    input  load_valid, load_data, load_last, instr_ready,
    output load_ready, instr_valid, instr, instr_pc
  );

  modport slave (
    output load_valid, load_data, load_last, instr_ready,
    input  load_ready, instr_valid, instr, instr_pc
  );

endinterface

// File: rtl/instr_fetch_unit_imem.sv
// Instruction memory: one write port, one synchronous read port, no reset.
// A read and write to the same address in one cycle returns the old word.
module imem_1w1r
  import fetch_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int WIDTH = INSTR_WIDTH,
  parameter int AW    = PC_WIDTH
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Loadable instruction memory plus program counter feeding decode over valid/ready.
// Build with HALT_OPCODE_EN to make HALT_OPCODE stop the run after it is delivered.
//
// state | meaning
// IDLE  | program (maybe) loaded, waiting for a load beat or start
// LOAD  | collecting program bytes at wr_ptr
// RUN   | streaming opcodes, wrapping at prog_len
// HALT  | halt opcode consumed; start restarts, a load beat reloads
module instr_fetch_unit
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  fetch_if.master           bus,
  input  logic              start,
  output logic [PC_WIDTH:0] prog_len,
  output logic              halted
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_LOAD = LOAD;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_HALT = HALT;

  logic [1:0]             state;
  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    wr_ptr;
  logic [PC_WIDTH-1:0]    mem_pc;
  logic                   mem_vld;
  logic [INSTR_WIDTH-1:0] rdata;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [PC_WIDTH-1:0]    instr_pc_q;
  logic                   instr_valid_q;

  logic                   load_ready_c;
  logic                   accept;
  logic                   load_close;
  logic [PC_WIDTH-1:0]    wr_addr;
  logic                   in_run;
  logic                   hs;
  logic                   load_out;
  logic                   issue;
  logic                   pc_last;
  logic [PC_WIDTH-1:0]    pc_next;
  logic                   start_ok;
  logic                   halt_hit;

  assign load_ready_c = (state != S_RUN);
  assign accept       = bus.load_valid && load_ready_c;
  assign wr_addr      = (state == S_LOAD) ? wr_ptr : '0;
  assign load_close   = accept && (state == S_LOAD) &&
                        (bus.load_last || (wr_ptr == PC_WIDTH'(IMEM_DEPTH - 1)));

  assign in_run   = (state == S_RUN);
  assign hs       = instr_valid_q && bus.instr_ready;
  // Two-stage pipe: memory word (mem_vld/mem_pc) then output register.
  // The memory stage only reads ahead when the output register can take its word.
  assign load_out = in_run && mem_vld && (!instr_valid_q || bus.instr_ready);
  assign issue    = in_run && (!mem_vld || load_out);

  assign pc_last  = ({1'b0, pc} == (prog_len - 7'd1));
  assign pc_next  = pc_last ? '0 : pc + 1'b1;

  assign start_ok = start && (prog_len != '0) && !accept &&
                    ((state == S_IDLE) || (state == S_HALT));

`ifdef HALT_OPCODE_EN
  assign halt_hit = in_run && hs && (instr_q == HALT_OPCODE);
  assign halted   = (state == S_HALT);
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  imem_1w1r #(
    .DEPTH (IMEM_DEPTH),
    .WIDTH (INSTR_WIDTH),
    .AW    (PC_WIDTH)
  ) u_imem (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_addr),
    .wdata (bus.load_data),
    .re    (issue),
    .raddr (pc),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      pc            <= '0;
      wr_ptr        <= '0;
      prog_len      <= '0;
      mem_pc        <= '0;
      mem_vld       <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (accept) begin
            // A new program invalidates the old one until it is closed.
            if (bus.load_last) begin
              prog_len <= 7'd1;
              wr_ptr   <= '0;
              state    <= S_IDLE;
            end else begin
              prog_len <= '0;
              wr_ptr   <= PC_WIDTH'(1);
              state    <= S_LOAD;
            end
          end else if (start_ok) begin
            state         <= S_RUN;
            pc            <= '0;
            mem_vld       <= 1'b0;
            instr_valid_q <= 1'b0;
          end
        end

        S_LOAD: begin
          if (accept) begin
            if (load_close) begin
              prog_len <= {1'b0, wr_ptr} + 7'd1;
              wr_ptr   <= '0;
              state    <= S_IDLE;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end

        S_RUN: begin
          if (halt_hit) begin
            state         <= S_HALT;
            pc            <= '0;
            mem_vld       <= 1'b0;
            instr_valid_q <= 1'b0;
          end else begin
            if (issue) begin
              pc      <= pc_next;
              mem_pc  <= pc;
              mem_vld <= 1'b1;
            end
            if (load_out) begin
              instr_q       <= rdata;
              instr_pc_q    <= mem_pc;
              instr_valid_q <= 1'b1;
            end else if (hs) begin
              instr_valid_q <= 1'b0;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.load_ready  = load_ready_c;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; inputs change and outputs are read 1 ns after posedge.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b0;
  logic              start   = 1'b0;
  logic [PC_WIDTH:0] prog_len;
  logic              halted;

  fetch_if bus();

  instr_fetch_unit dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .start    (start),
    .prog_len (prog_len),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] exp4 [4] = '{8'h01, 8'h06, 8'h0B, 8'h10};
  logic       rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #4;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic load_beat(input logic [7:0] d, input logic last);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    check("load_ready", bus.load_ready, 1);
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic load_prog4();
    for (int i = 0; i < 4; i++) load_beat(exp4[i], i == 3);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int idx;
    logic       stall_prev;
    logic [7:0] hold_i;
    logic [5:0] hold_pc;

    bus.load_valid  = 1'b0;
    bus.load_data   = '0;
    bus.load_last   = 1'b0;
    bus.instr_ready = 1'b0;

    // Reset state
    #2;
    check("rst_valid", bus.instr_valid, 0);
    check("rst_load_ready", bus.load_ready, 1);
    check("rst_prog_len", prog_len, 0);
    check("rst_instr", bus.instr, 0);
    check("rst_pc", bus.instr_pc, 0);
    check("rst_halted", halted, 0);
    #3;
    do_reset();

    // Four-byte program
    load_prog4();
    check("len4", prog_len, 4);
    check("idle_load_ready", bus.load_ready, 1);
    check("idle_valid", bus.instr_valid, 0);

    // Load beat together with start: load wins, start in LOAD ignored
    start = 1'b1;
    load_beat(8'h01, 1'b0);
    load_beat(8'h06, 1'b0);
    start = 1'b0;
    check("len_cleared_in_load", prog_len, 0);
    load_beat(8'h0B, 1'b0);
    load_beat(8'h10, 1'b1);
    check("len4_reload", prog_len, 4);
    check("no_run_after_load", bus.instr_valid, 0);

    // Full-throughput streaming
    bus.instr_ready = 1'b1;
    start_pulse();
    check("lat_e0", bus.instr_valid, 0);
    check("run_load_ready", bus.load_ready, 0);
    tick();
    check("lat_e1", bus.instr_valid, 0);
    tick();
    for (int k = 0; k < 6; k++) begin
      check("stream_valid", bus.instr_valid, 1);
      check("stream_instr", bus.instr, exp4[k % 4]);
      check("stream_pc", bus.instr_pc, k % 4);
      tick();
    end

    // Backpressure with ready pattern 1,0,0,1
    do_reset();
    load_prog4();
    bus.instr_ready = 1'b0;
    start_pulse();
    idx = 0;
    stall_prev = 1'b0;
    hold_i = '0;
    hold_pc = '0;
    for (int c = 0; c < 24; c++) begin
      if (stall_prev) begin
        check("stall_valid", bus.instr_valid, 1);
        check("stall_instr", bus.instr, hold_i);
        check("stall_pc", bus.instr_pc, hold_pc);
      end
      bus.instr_ready = rdy_pat[c % 4];
      if (bus.instr_valid && bus.instr_ready) begin
        check("bp_instr", bus.instr, exp4[idx % 4]);
        check("bp_pc", bus.instr_pc, idx % 4);
        idx++;
      end
      stall_prev = bus.instr_valid && !bus.instr_ready;
      hold_i     = bus.instr;
      hold_pc    = bus.instr_pc;
      tick();
    end
    check("bp_handshakes", idx, 11);

    // 64 beats without load_last close the program
    do_reset();
    for (int i = 0; i < 64; i++) load_beat(8'(i) ^ 8'hC3, 1'b0);
    check("len64", prog_len, 64);
    check("len64_load_ready", bus.load_ready, 1);
    bus.instr_ready = 1'b1;
    start_pulse();
    tick();
    tick();
    for (int k = 0; k < 66; k++) begin
      check("p64_instr", bus.instr, 8'(k % 64) ^ 8'hC3);
      check("p64_pc", bus.instr_pc, k % 64);
      tick();
    end

    // Asynchronous reset in the middle of RUN
    check("pre_rst_valid", bus.instr_valid, 1);
    reset_n = 1'b0;
    #1;
    check("midrun_rst_valid", bus.instr_valid, 0);
    check("midrun_rst_len", prog_len, 0);
    check("midrun_rst_load_ready", bus.load_ready, 1);
    #3;
    reset_n = 1'b1;
    tick();

    // start with no program is ignored
    start_pulse();
    for (int c = 0; c < 10; c++) begin
      check("empty_start_valid", bus.instr_valid, 0);
      tick();
    end
    check("empty_start_load_ready", bus.load_ready, 1);

    // 65th beat opens a new program at address 0
    for (int i = 0; i < 64; i++) load_beat(8'(i) ^ 8'hC3, 1'b0);
    check("len64_b", prog_len, 64);
    load_beat(8'hAA, 1'b1);
    check("len1", prog_len, 1);
    start_pulse();
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      check("p1_instr", bus.instr, 8'hAA);
      check("p1_pc", bus.instr_pc, 0);
      check("p1_halted", halted, 0);
      tick();
    end

`ifdef HALT_OPCODE_EN
    do_reset();
    load_beat(8'h05, 1'b0);
    load_beat(8'hFF, 1'b0);
    load_beat(8'h09, 1'b1);
    check("halt_len", prog_len, 3);
    bus.instr_ready = 1'b1;
    start_pulse();
    tick();
    tick();
    check("halt_i0", bus.instr, 8'h05);
    check("halt_pc0", bus.instr_pc, 0);
    tick();
    check("halt_i1", bus.instr, 8'hFF);
    check("halt_pc1", bus.instr_pc, 1);
    check("halt_v1", bus.instr_valid, 1);
    tick();
    for (int c = 0; c < 5; c++) begin
      check("halted", halted, 1);
      check("halt_valid", bus.instr_valid, 0);
      tick();
    end
    check("halt_load_ready", bus.load_ready, 1);
    start_pulse();
    check("restart_halted", halted, 0);
    tick();
    tick();
    check("restart_valid", bus.instr_valid, 1);
    check("restart_pc", bus.instr_pc, 0);
    check("restart_instr", bus.instr, 8'h05);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
